// File: rtl/lighting_pkg.sv
// -----------------------------------------------------------------------------
// lighting_pkg
// Shared definitions for the dynamic lighting path. The upstream controller
// produces a 3-bit colour code; this package fixes which bit drives which LED
// channel so both ends agree.
//   CH_R / CH_G / CH_B : channel indices (red = bit 2, green = bit 1, blue = bit 0)
//   colour_t           : named colour encodings
//   chan_on()          : colour code + channel index -> channel requested on
// -----------------------------------------------------------------------------
package lighting_pkg;

    typedef logic [1:0] ch_idx_t;

    localparam int      NUM_CH = 3;
    localparam ch_idx_t CH_R   = 2'd2;
    localparam ch_idx_t CH_G   = 2'd1;
    localparam ch_idx_t CH_B   = 2'd0;

    typedef enum logic [2:0] {
        COL_OFF     = 3'b000,
        COL_BLUE    = 3'b001,
        COL_GREEN   = 3'b010,
        COL_CYAN    = 3'b011,
        COL_RED     = 3'b100,
        COL_MAGENTA = 3'b101,
        COL_YELLOW  = 3'b110,
        COL_WHITE   = 3'b111
    } colour_t;

    // Colour-bit-to-channel mapping; an unused index maps to "off".
    function automatic logic chan_on(input logic [2:0] colour, input ch_idx_t ch);
        logic on;
        case (ch)
            CH_R:    on = colour[2];
            CH_G:    on = colour[1];
            CH_B:    on = colour[0];
            default: on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// -----------------------------------------------------------------------------
// pwm_fade_channel
// One LED channel: registers its on/off target, ramps a duty value toward it
// one step per prescaler tick, latches the displayed (active) duty only at PWM
// period boundaries, and drives the pin from a registered compare.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   on_req    : channel requested on by the current colour code
//   en        : 0 forces the pin low (tick is already gated upstream)
//   tick      : one-cycle ramp step strobe
//   wrap      : one-cycle strobe on the cycle the shared counter wraps to 0
//   pwm_cnt   : shared free-running PWM counter
//   led       : registered PWM output, active-high
//   match     : ramp equals incoming target and display equals ramp
// -----------------------------------------------------------------------------
module pwm_fade_channel
    import lighting_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                on_req,
    input  logic                en,
    input  logic                tick,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                match
);

    localparam logic [PWM_BITS-1:0] MAX_DUTY = '1;

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] target_nxt;
    logic [PWM_BITS-1:0] ramp;
    logic [PWM_BITS-1:0] active;

    // Single step toward the target; the target is always 0 or MAX_DUTY, so
    // stepping only while unequal can never wrap past either end.
    function automatic logic [PWM_BITS-1:0] ramp_step(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        logic [PWM_BITS-1:0] nxt;
        if (cur < tgt)      nxt = cur + 1'b1;
        else if (cur > tgt) nxt = cur - 1'b1;
        else                nxt = cur;
        return nxt;
    endfunction

    assign target_nxt = on_req ? MAX_DUTY : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
            ramp   <= '0;
            active <= '0;
            led    <= 1'b0;
        end else begin
            target <= target_nxt;
            if (tick)
                ramp <= ramp_step(ramp, target);
            // Compare value only changes between PWM periods, so a period is
            // never cut short or stretched.
            if (wrap)
                active <= ramp;
            // pwm_cnt never reaches MAX_DUTY, so duty MAX_DUTY is a constant 1.
            led <= en && (pwm_cnt < active);
        end
    end

    // Compared against the incoming target so settled drops on the first
    // edge after a colour change rather than one cycle later.
    assign match = (ramp == target_nxt) && (active == ramp);

endmodule

// File: rtl/led_colour_fader.sv
// -----------------------------------------------------------------------------
// led_colour_fader
// Drives the red/green/blue LED pins from the lighting controller's colour code,
// fading each channel between off and full brightness instead of stepping.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   colour[2:0]       : colour code (bit2 red, bit1 green, bit0 blue)
//   en                : 1 run, 0 LEDs dark and fades frozen
//   led_r/led_g/led_b : PWM pin drives, active-high
//   settled           : every channel is displaying its target duty
// Parameters:
//   PWM_BITS : PWM counter / duty width, MAX_DUTY = 2**PWM_BITS - 1
//   RAMP_DIV : clk cycles per ramp step, must be >= 2
// -----------------------------------------------------------------------------
module led_colour_fader
    import lighting_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] colour,
    input  logic       en,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       settled
);

    localparam int                  PRE_W    = $clog2(RAMP_DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
    // Counter runs 0..MAX_DUTY-1, so the period is MAX_DUTY cycles.
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [PRE_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                wrap;
    logic                on_r, on_g, on_b;
    logic                match_r, match_g, match_b;

    // Tick is gated by en so the ramps freeze along with the prescaler.
    assign tick = en && (presc == PRE_LAST);
    assign wrap = (pwm_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
            settled <= 1'b0;
        end else begin
            if (en)
                presc <= tick ? '0 : presc + 1'b1;
            // Free-running regardless of en so the period phase is preserved.
            pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
            settled <= match_r && match_g && match_b;
        end
    end

    assign on_r = chan_on(colour, CH_R);
    assign on_g = chan_on(colour, CH_G);
    assign on_b = chan_on(colour, CH_B);

    pwm_fade_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .clk     (clk),
        .rst     (rst),
        .on_req  (on_r),
        .en      (en),
        .tick    (tick),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt),
        .led     (led_r),
        .match   (match_r)
    );

    pwm_fade_channel #(.PWM_BITS(PWM_BITS)) u_green (
        .clk     (clk),
        .rst     (rst),
        .on_req  (on_g),
        .en      (en),
        .tick    (tick),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt),
        .led     (led_g),
        .match   (match_g)
    );

    pwm_fade_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk     (clk),
        .rst     (rst),
        .on_req  (on_b),
        .en      (en),
        .tick    (tick),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt),
        .led     (led_b),
        .match   (match_b)
    );

endmodule

// File: doc/led_colour_fader.md
Name: led_colour_fader

Overview:
- Downstream stage of the dynamic lighting controller. Consumes its 3-bit colour code and drives three physical LED pins (red, green, blue).
- Each channel ramps its brightness smoothly toward the on/off level the colour code requests, so colour changes fade instead of stepping.
- Brightness is produced by a shared free-running PWM counter. Compare values are updated glitch-free, only at PWM period boundaries.

Parameters:
- PWM_BITS, 8, width of the PWM counter and duty registers; MAX_DUTY = 2^PWM_BITS - 1.
- RAMP_DIV, 1024, clk cycles per ramp step (one duty increment or decrement); must be >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- colour  input  3  colour code from upstream; bit2 = red, bit1 = green, bit0 = blue
- en  input  1  1 = normal operation; 0 = LEDs dark and ramps frozen
- led_r  output  1  red PWM drive, active-high
- led_g  output  1  green PWM drive, active-high
- led_b  output  1  blue PWM drive, active-high
- settled  output  1  high when every channel's displayed duty equals its target

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.

Reset values:
- target, ramp duty and active duty all 0.
- Prescaler 0, PWM counter 0.
- led_r, led_g, led_b = 0; settled = 0.

Target:
- colour is registered every clk.
- A channel's target is MAX_DUTY if its colour bit is 1, otherwise 0.
- 000 (all off) and 111 (white) are legal and handled literally.

Prescaler:
- Counts 0..RAMP_DIV-1 and wraps; emits a one-cycle tick at RAMP_DIV-1.
- Runs only while en = 1; holds its value while en = 0.

Ramp:
- On a tick, each channel's ramp duty moves 1 toward its target, or holds if equal.
- No overflow or underflow past 0 or MAX_DUTY.
- A target change mid-ramp reverses direction on the next tick. The prescaler is not restarted.

PWM:
- pwm_cnt counts 0..MAX_DUTY-1 and wraps, giving a period of MAX_DUTY clk cycles.
- On the cycle pwm_cnt wraps to 0, active duty is loaded from ramp duty.
- led_x is registered as (en && pwm_cnt < active_x): one clk of latency from counter to pin.
- Duty 0 gives a constant 0; duty MAX_DUTY gives a constant 1.

en:
- When en = 0: outputs are 0 from the next clk, the prescaler and ramps freeze, pwm_cnt keeps running.
- When en returns to 1, the fade resumes from the frozen duties.

settled:
- Registered: settled = AND over channels of (ramp == target && active == ramp).
- Deasserts the clk after any colour change that alters a target.

Reset mid-fade:
- Everything returns to reset values immediately (asynchronous).
- The fade restarts from 0 toward the current colour.

Full fade time:
- 0 to MAX_DUTY takes MAX_DUTY*RAMP_DIV clk cycles, plus at most one PWM period before it is displayed.

Decomposition:
- Shared package (lighting_pkg): channel index constants (CH_R=2, CH_G=1, CH_B=0) and the colour-bit-to-channel mapping.
- The same package is imported by the upstream controller for its colour encodings.
- Sub-module pwm_fade_channel, instantiated three times. It holds the target, ramp and active duty, the compare logic and the output flop.
- The top level holds the prescaler, the shared pwm_cnt, the wrap strobe and settled.

Test Plan (PWM_BITS=4, RAMP_DIV=4, so MAX_DUTY=15 and period 15):
1. Reset released with colour=100, en=1 -> led_g and led_b stay 0. Red ramp duty reaches 15 at 60 clk. led_r is constant 1 and settled=1 within 15+2 clk after that.
2. Settled at 100, then colour switched to 010 -> settled falls next clk. Red decrements and green increments 1 per 4 clk. After 60 clk plus one period: led_r constant 0, led_g constant 1.
3. Mid-fade reversal: colour 000 to 001, then back to 000 after 20 clk (blue duty 5) -> blue decrements from 5. It reaches 0 after 20 more clk and never exceeds 5.
4. Duty check: freeze at blue duty 6 via en toggling. With en=1, led_b is high for exactly 6 of every 15 clk. The duty changes only at a pwm_cnt wrap.
5. en=0 mid-fade -> all LEDs 0 next clk and ramp duties unchanged for 100 clk. en=1 -> the fade resumes from the held values.
6. Async reset asserted mid-clock during a fade with colour=111 -> outputs and settled go 0 without waiting for a clk edge. After release, all three channels ramp together to 15.
